// File: rtl/axi4_lite_pkg.sv
// Shared types and encodings for the AXI4-Lite initiator and its watchdog.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    localparam logic [2:0] PROT_INSN  = 3'b100;
    localparam logic [2:0] PROT_DATA  = 3'b000;
    localparam logic [3:0] WSTRB_READ = 4'b0000;

endpackage

// File: rtl/bus_watchdog.sv
// Stall watchdog: counts busy cycles and raises a sticky flag when the limit is reached.
module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    output logic timeout
);

    logic [31:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            timeout <= 1'b0;
        end else if (!busy) begin
            count <= '0;
        end else if (TIMEOUT_CYCLES != 0 && !timeout) begin
            count <= count + 32'd1;
            if (count + 32'd1 == TIMEOUT_CYCLES)
                timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/axi4_lite_initiator.sv
// Bridges the core's native valid/ready memory port onto AXI4-Lite, one transaction at a time.
module axi4_lite_initiator
    import axi4_lite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int          CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_valid,
    input  logic                 mem_instr,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic                 mem_ready,
    output logic [31:0]          mem_rdata,
    output logic                 mem_axi_awvalid,
    input  logic                 mem_axi_awready,
    output logic [31:0]          mem_axi_awaddr,
    output logic [2:0]           mem_axi_awprot,
    output logic                 mem_axi_wvalid,
    input  logic                 mem_axi_wready,
    output logic [31:0]          mem_axi_wdata,
    output logic [3:0]           mem_axi_wstrb,
    input  logic                 mem_axi_bvalid,
    output logic                 mem_axi_bready,
    output logic                 mem_axi_arvalid,
    input  logic                 mem_axi_arready,
    output logic [31:0]          mem_axi_araddr,
    output logic [2:0]           mem_axi_arprot,
    input  logic                 mem_axi_rvalid,
    output logic                 mem_axi_rready,
    input  logic [31:0]          mem_axi_rdata,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] wr_count
);

    state_t state, state_nxt;
    logic   aw_done, w_done, is_write;

    assign mem_axi_awprot = PROT_DATA;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt       = state;
        mem_ready       = 1'b0;
        mem_axi_arvalid = 1'b0;
        mem_axi_awvalid = 1'b0;
        mem_axi_wvalid  = 1'b0;
        mem_axi_rready  = 1'b0;
        mem_axi_bready  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid)
                    state_nxt = (mem_wstrb == WSTRB_READ) ? RD_ADDR : WR_REQ;
            end
            RD_ADDR: begin
                mem_axi_arvalid = 1'b1;
                if (mem_axi_arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                mem_axi_rready = 1'b1;
                if (mem_axi_rvalid) state_nxt = DONE;
            end
            WR_REQ: begin
                mem_axi_awvalid = !aw_done;
                mem_axi_wvalid  = !w_done;
                // A channel whose flag is clear is driving valid, so its ready alone completes it.
                if ((aw_done || mem_axi_awready) && (w_done || mem_axi_wready))
                    state_nxt = WR_RESP;
            end
            WR_RESP: begin
                mem_axi_bready = 1'b1;
                if (mem_axi_bvalid) state_nxt = DONE;
            end
            DONE: begin
                mem_ready = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == IDLE) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == WR_REQ) begin
            if (mem_axi_awvalid && mem_axi_awready) aw_done <= 1'b1;
            if (mem_axi_wvalid && mem_axi_wready)   w_done  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_axi_araddr <= '0;
            mem_axi_arprot <= PROT_DATA;
            mem_axi_awaddr <= '0;
            mem_axi_wdata  <= '0;
            mem_axi_wstrb  <= '0;
            mem_rdata      <= '0;
            is_write       <= 1'b0;
            rd_count       <= '0;
            wr_count       <= '0;
        end else begin
            if (state == IDLE && mem_valid) begin
                if (mem_wstrb == WSTRB_READ) begin
                    mem_axi_araddr <= mem_addr;
                    mem_axi_arprot <= mem_instr ? PROT_INSN : PROT_DATA;
                    is_write       <= 1'b0;
                end else begin
                    mem_axi_awaddr <= mem_addr;
                    mem_axi_wdata  <= mem_wdata;
                    mem_axi_wstrb  <= mem_wstrb;
                    is_write       <= 1'b1;
                end
            end
            if (state == RD_DATA && mem_axi_rvalid)
                mem_rdata <= mem_axi_rdata;
            if (state == DONE) begin
                if (is_write) wr_count <= wr_count + CNT_WIDTH'(1);
                else          rd_count <= rd_count + CNT_WIDTH'(1);
            end
        end
    end

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .busy   (state != IDLE),
        .timeout(timeout)
    );

endmodule
